// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: sequences IF/ID/EX/MEM/WB and drives the ALU and datapath controls.
// Optional ILLEGAL_TRAP_EN: unknown op/funct halts the machine and raises Illegal.
module multicycle_ctrl #(
    parameter int unsigned OPW      = 6,
    parameter int unsigned FW       = 6,
    parameter int unsigned ALUCTR_W = 3
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic [OPW-1:0]      op,
    input  logic [FW-1:0]       funct,
    input  logic                Zero,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                PCWre,
    output logic [1:0]          PCSrc,
    output logic                IRWre,
    output logic                ALUSrcB,
    output logic                ExtSel,
    output logic                RegDst,
    output logic                MemToReg,
    output logic                RegWre,
    output logic                MemRd,
    output logic                MemWre,
    output logic [3:0]          State,
`ifdef ILLEGAL_TRAP_EN
    output logic                Illegal,
`endif
    output logic                Halt
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

    localparam logic [FW-1:0] FN_ADD = FW'(6'b100000);
    localparam logic [FW-1:0] FN_SUB = FW'(6'b100010);
    localparam logic [FW-1:0] FN_AND = FW'(6'b100100);
    localparam logic [FW-1:0] FN_OR  = FW'(6'b100101);
    localparam logic [FW-1:0] FN_SLT = FW'(6'b101011);

    localparam logic [ALUCTR_W-1:0] ALU_ADD = ALUCTR_W'(3'b000);
    localparam logic [ALUCTR_W-1:0] ALU_SUB = ALUCTR_W'(3'b001);
    localparam logic [ALUCTR_W-1:0] ALU_AND = ALUCTR_W'(3'b010);
    localparam logic [ALUCTR_W-1:0] ALU_OR  = ALUCTR_W'(3'b011);
    localparam logic [ALUCTR_W-1:0] ALU_SLT = ALUCTR_W'(3'b100);

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EXR = 4'd2,
        S_EXI = 4'd3,
        S_EXA = 4'd4,
        S_EXB = 4'd5,
        S_MRD = 4'd6,
        S_MWR = 4'd7,
        S_WBR = 4'd8,
        S_WBI = 4'd9,
        S_WBL = 4'd10,
        S_HLT = 4'd15
    } state_t;

    state_t state_q, state_d;

    logic [ALUCTR_W-1:0] r_alu;
    logic                funct_ok;
    logic [ALUCTR_W-1:0] alu_ctr;
    logic [1:0]          pc_src;
    logic                pc_wre, ir_wre, alu_src_b, ext_sel, reg_dst;
    logic                mem_to_reg, reg_wre, mem_rd, mem_wre;
`ifdef ILLEGAL_TRAP_EN
    logic                trap;
`endif

    // R-type funct to ALU operation; unknown functs fall back to add
    always_comb begin
        r_alu    = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state control decode
    always_comb begin
        state_d    = state_q;
        alu_ctr    = ALU_ADD;
        pc_wre     = 1'b0;
        pc_src     = PC_SEQ;
        ir_wre     = 1'b0;
        alu_src_b  = 1'b0;
        ext_sel    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wre    = 1'b0;
        mem_rd     = 1'b0;
        mem_wre    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap       = 1'b0;
`endif
        case (state_q)
            S_IF: begin
                ir_wre  = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (op)
                    OP_J: begin
                        pc_wre  = 1'b1;
                        pc_src  = PC_JMP;
                        state_d = S_IF;
                    end
                    OP_HALT:         state_d = S_HLT;
                    OP_RTYPE:        state_d = S_EXR;
                    OP_ADDI, OP_ORI: state_d = S_EXI;
                    OP_LW, OP_SW:    state_d = S_EXA;
                    OP_BEQ:          state_d = S_EXB;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        trap    = 1'b1;
                        state_d = S_HLT;
`else
                        pc_wre  = 1'b1;
                        state_d = S_IF;
`endif
                    end
                endcase
            end
            S_EXR: begin
                alu_ctr = r_alu;
                state_d = S_WBR;
`ifdef ILLEGAL_TRAP_EN
                if (!funct_ok) begin
                    trap    = 1'b1;
                    state_d = S_HLT;
                end
`endif
            end
            S_WBR: begin
                alu_ctr = r_alu;
                reg_wre = 1'b1;
                reg_dst = 1'b1;
                pc_wre  = 1'b1;
                state_d = S_IF;
            end
            S_EXI, S_WBI: begin
                alu_src_b = 1'b1;
                alu_ctr   = (op == OP_ORI) ? ALU_OR : ALU_ADD;
                ext_sel   = (op != OP_ORI);
                if (state_q == S_EXI) begin
                    state_d = S_WBI;
                end else begin
                    reg_wre = 1'b1;
                    pc_wre  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXA: begin
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                state_d   = (op == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                mem_rd    = 1'b1;
                state_d   = S_WBL;
            end
            S_MWR: begin
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                mem_wre   = 1'b1;
                pc_wre    = 1'b1;
                state_d   = S_IF;
            end
            S_WBL: begin
                alu_src_b  = 1'b1;
                ext_sel    = 1'b1;
                reg_wre    = 1'b1;
                mem_to_reg = 1'b1;
                pc_wre     = 1'b1;
                state_d    = S_IF;
            end
            S_EXB: begin
                alu_ctr = ALU_SUB;
                ext_sel = 1'b1;
                pc_wre  = 1'b1;
                pc_src  = Zero ? PC_BR : PC_SEQ;
                state_d = S_IF;
            end
            S_HLT:   state_d = S_HLT;
            default: state_d = S_IF;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Illegal <= 1'b0;
        end else if (trap) begin
            Illegal <= 1'b1;
        end
    end
`else
    logic unused_funct_ok;
    assign unused_funct_ok = funct_ok;
`endif

    // Enables are gated by reset so nothing fires while RST_n is held low
    assign PCWre    = pc_wre  & RST_n;
    assign IRWre    = ir_wre  & RST_n;
    assign RegWre   = reg_wre & RST_n;
    assign MemRd    = mem_rd  & RST_n;
    assign MemWre   = mem_wre & RST_n;
    assign ALUctr   = alu_ctr;
    assign PCSrc    = pc_src;
    assign ALUSrcB  = alu_src_b;
    assign ExtSel   = ext_sel;
    assign RegDst   = reg_dst;
    assign MemToReg = mem_to_reg;
    assign State    = state_q;
    assign Halt     = (state_q == S_HLT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench for multicycle_ctrl against an instruction-level model.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic [5:0] op, funct;
    logic       Zero;
    logic [2:0] ALUctr;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre, ALUSrcB, ExtSel, RegDst, MemToReg, RegWre, MemRd, MemWre;
    logic [3:0] State;
    logic       Halt;
`ifdef ILLEGAL_TRAP_EN
    logic       Illegal;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .CLK(CLK), .RST_n(RST_n), .op(op), .funct(funct), .Zero(Zero),
        .ALUctr(ALUctr), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
        .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWre(RegWre), .MemRd(MemRd), .MemWre(MemWre), .State(State),
`ifdef ILLEGAL_TRAP_EN
        .Illegal(Illegal),
`endif
        .Halt(Halt)
    );

    always #5 CLK = ~CLK;

    typedef enum int {C_J, C_R, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_HALT, C_NOP, C_TRAP, C_TRAPF} cls_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic funct_known(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101011};
    endfunction

    function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000010: return C_J;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b001101: return C_ORI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b111111: return C_HALT;
`ifdef ILLEGAL_TRAP_EN
            6'b000000: return funct_known(f) ? C_R : C_TRAPF;
            default:   return C_TRAP;
`else
            6'b000000: return C_R;
            default:   return C_NOP;
`endif
        endcase
    endfunction

    function automatic int alu_of(input cls_t cls, input logic [5:0] f);
        case (cls)
            C_ORI: return 3;
            C_BEQ: return 1;
            C_R, C_TRAPF: begin
                case (f)
                    6'b100010: return 1;
                    6'b100100: return 2;
                    6'b100101: return 3;
                    6'b101011: return 4;
                    default:   return 0;
                endcase
            end
            default: return 0;
        endcase
    endfunction

    function automatic int lat_of(input cls_t cls);
        case (cls)
            C_BEQ, C_TRAPF:          return 3;
            C_R, C_ADDI, C_ORI, C_SW: return 4;
            C_LW:                    return 5;
            default:                 return 2;
        endcase
    endfunction

    function automatic int st_of(input cls_t cls, input int c);
        if (c == 0) return 0;
        if (c == 1) return 1;
        case (cls)
            C_R, C_TRAPF:  return (c == 2) ? 2 : 8;
            C_ADDI, C_ORI: return (c == 2) ? 3 : 9;
            C_LW:          return (c == 2) ? 4 : ((c == 3) ? 6 : 10);
            C_SW:          return (c == 2) ? 4 : 7;
            C_BEQ:         return 5;
            default:       return 15;
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_enables"}, {PCWre, IRWre, RegWre, MemRd, MemWre}, 0);
        check({tag, "_state"}, State, 0);
        check({tag, "_aluctr"}, ALUctr, 0);
        check({tag, "_halt"}, Halt, 0);
    endtask

    // Reset asserted mid-cycle, released just after an edge so the next negedge is an IF cycle
    task automatic do_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        #1;
        check_quiet("rst_async");
        @(posedge CLK);
        #1;
        check_quiet("rst_held");
`ifdef ILLEGAL_TRAP_EN
        check("rst_illegal", Illegal, 0);
`endif
        RST_n = 1'b1;
    endtask

    // zf < 0 drives Zero randomly each cycle, otherwise holds it at zf
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zf);
        cls_t cls;
        int   lat;
        logic halts, last, wr;
        cls   = classify(o, f);
        lat   = lat_of(cls);
        halts = cls inside {C_HALT, C_TRAP, C_TRAPF};
        for (int c = 0; c < lat; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                op    = o;
                funct = f;
            end
            Zero = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
            #1;
            last = (c == lat - 1) && !halts;
            wr   = last && (cls inside {C_R, C_ADDI, C_ORI, C_LW});
            check("state", State, st_of(cls, c));
            check("irwre", IRWre, c == 0);
            check("pcwre", PCWre, last);
            if (last) check("pcsrc", PCSrc, (cls == C_J) ? 2 : ((cls == C_BEQ && Zero) ? 1 : 0));
            check("regwre", RegWre, wr);
            check("memrd", MemRd, cls == C_LW && c == 3);
            check("memwre", MemWre, cls == C_SW && c == 3);
            check("aluctr", ALUctr, (c >= 2) ? alu_of(cls, f) : 0);
            if (c >= 2 && (cls inside {C_ADDI, C_ORI, C_LW, C_SW})) begin
                check("alusrcb", ALUSrcB, 1);
                check("extsel", ExtSel, cls != C_ORI);
            end
            if (wr) begin
                check("regdst", RegDst, cls == C_R);
                check("memtoreg", MemToReg, cls == C_LW);
            end
            check("halt", Halt, 0);
        end
        if (halts) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge CLK);
                Zero = 1'($urandom_range(0, 1));
                #1;
                check("hlt_state", State, 15);
                check("hlt_halt", Halt, 1);
                check("hlt_enables", {PCWre, IRWre, RegWre, MemRd, MemWre}, 0);
                check("hlt_aluctr", ALUctr, 0);
`ifdef ILLEGAL_TRAP_EN
                check("hlt_illegal", Illegal, cls != C_HALT);
`endif
            end
            do_reset();
        end
    endtask

    task automatic reset_mid_lw();
        @(negedge CLK);
        op    = 6'b100011;
        funct = 6'($urandom);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("midlw_exa", State, 4);
        RST_n = 1'b0;
        #1;
        check_quiet("midlw_rst");
        @(posedge CLK);
        #1;
        check_quiet("midlw_edge");
        @(negedge CLK);
        check_quiet("midlw_later");
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
    endtask

    logic [5:0] ops [7];
    logic [5:0] fns [5];

    initial begin
        ops = '{6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b001101, 6'b100011, 6'b101011};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101011};
        RST_n = 1'b0;
        op    = 6'b0;
        funct = 6'b0;
        Zero  = 1'b0;
        #3;
        check_quiet("reset");
        check("reset_pcsrc", PCSrc, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;

        run_instr(6'b000000, 6'b100010, -1);
        run_instr(6'b000100, 6'b000000, 1);
        run_instr(6'b000100, 6'b000000, 0);
        run_instr(6'b100011, 6'b010101, -1);
        run_instr(6'b001101, 6'b000000, -1);
        run_instr(6'b000010, 6'b000000, -1);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] o, f;
            o = ops[$urandom_range(0, 6)];
            f = (o == 6'b000000) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(o, f, -1);
        end

        reset_mid_lw();
        run_instr(6'b000000, 6'b100101, -1);
        run_instr(6'b000000, 6'b111000, -1);
        run_instr(6'b010101, 6'b000000, -1);
        run_instr(6'b111111, 6'b000000, -1);
        run_instr(6'b001000, 6'b000000, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
